pipe_exe_backend: RTL
=====================

Name: pipe_exe_backend

Overview:
- Consumer of the ID-stage decode/operand bundle and producer of the EX- and MEM-stage forwarding/hazard signals that ID reads back (`ern`, `ewreg`, `em2reg`, `ealu`, `mrn`, `mwreg`, `mm2reg`, `malu`).
- Contains the ID/EX pipeline register with bubble insertion, the EX-stage ALU with shifter and jal link path, and the EX/MEM pipeline register.
- Sits between pipeid and the data-memory stage of the 5-stage MIPS pipeline.

Parameters:
- LINK_REG, 5'd31, destination register forced for jal.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clock  in  1  system clock; all registers update on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wpcir  in  1  1 = load-use stall from ID; the ID/EX register captures a bubble.
- dpc4  in  32  PC+4 of the instruction in ID.
- da, db  in  32  forwarded operands from ID.
- dimm  in  32  sign/zero-extended immediate, or shift amount.
- drn  in  5  destination register from ID.
- daluc  in  4  ALU control.
- dwreg, dm2reg, dwmem, daluimm, dshift, djal  in  1  each; control bits from ID.
- ealu  out  32  EX result: ALU output, or epc4+4 when ejal.
- ern  out  5  EX destination; LINK_REG when ejal.
- ewreg, em2reg  out  1  EX-stage control, for forwarding and stall detection.
- malu  out  32  registered EX result in MEM.
- mb  out  32  store data in MEM (registered eb).
- mrn  out  5  MEM destination.
- mwreg, mm2reg, mwmem  out  1  MEM-stage control.
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Clock port `clock`, reset port `resetn`.
- Reset value: every registered output and internal E-stage register is 0.
  - Consequences: `ern`=0, `ealu`=0 (the ALU of zero operands under ADD), `bubble_cnt`=0.
  - Reset asserted mid-operation clears both stages immediately. Nothing in flight survives.
- ID/EX register, every rising edge:
  - wpcir=0: capture {dpc4, da, db, dimm, drn, daluc, dwreg, dm2reg, dwmem, daluimm, dshift, djal} into the e* registers.
  - wpcir=1: capture a bubble. ewreg=0, em2reg=0, ewmem=0, ejal=0. Data fields are captured normally (don't-care).
  - Bubbles therefore cannot write registers or memory.
- EX datapath (combinational from the e* registers):
  - a = eshift ? eimm : ea.
  - b = ealuimm ? eimm : eb.
  - Shift amount is a[4:0]; shifts act on b.
- ALU encoding (daluc):
  - x000 ADD, x100 SUB, x001 AND, x101 OR.
  - x010 XOR, x110 LUI (b<<16).
  - 0011 SLL, 0111 SRL, 1111 SRA.
  - Any other code yields 0.
  - Arithmetic is 32-bit modulo 2^32; overflow is ignored, with no trap.
- jal:
  - ealu = epc4 + 4, the return address of the instruction after the delay slot.
  - ern = LINK_REG. ewreg is as decoded.
  - Otherwise ern = ern_reg.
- EX/MEM register, every rising edge:
  - malu<=ealu, mb<=eb, mrn<=ern, mwreg<=ewreg, mm2reg<=em2reg, mwmem<=ewmem.
  - No stall input: the MEM stage never stalls.
- Latency: decode bundle to e* outputs is 1 cycle; to m* outputs is 2 cycles.
- Two consecutive wpcir=1 cycles insert two bubbles. There is no merging.
- bubble_cnt:
  - Increments on each edge where wpcir=1.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.

Decomposition:
- Shared package `pipe_pkg`:
  - ALU code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA).
  - LINK_REG default.
  - A typedef for the ID/EX control bundle.
- One sub-module, `pipe_alu` (a, b, aluc -> r): purely combinational ALU. Both pipeline registers stay in the top.

Test Plan:
- Reset release, all inputs 0, one clock edge -> every m* output 0, bubble_cnt=0.
- ADD forwarding:
  - Stimulus: da=5, db=7, daluc=0000, dwreg=1, drn=8, wpcir=0.
  - After edge 1: ealu=12, ern=8, ewreg=1.
  - After edge 2: malu=12, mrn=8, mwreg=1.
- Load-use stall:
  - Stimulus: lw in EX (em2reg=1) and ID presents dependent add with wpcir=1.
  - Next edge: ewreg=0, em2reg=0, ewmem=0; bubble_cnt=1.
  - Following edge with wpcir=0: add enters EX.
- jal:
  - Stimulus: dpc4=0x00400008, djal=1, dwreg=1, drn=0.
  - Next edge: ealu=0x0040000C, ern=31.
- Shifts and LUI:
  - SRA: dshift=1, dimm=4, db=0x80000000, daluc=1111 -> ealu=0xF8000000.
  - LUI: daluimm=1, dimm=0x1234, daluc=0110 -> ealu=0x12340000.
- Async reset mid-stream:
  - Stimulus: pull resetn low between edges while mwreg=1, then hold wpcir=1 for 2^CNT_W+3 cycles after release.
  - Response: mwreg drops immediately, without waiting for an edge.
  - bubble_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM backend of the 5-stage MIPS pipeline:
// ALU codes, link register default and the ID/EX control bundle.
package pipe_pkg;

  // Bit 3 is ignored for every code except the shifts.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [4:0] DEFAULT_LINK_REG = 5'd31;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       shift;
    logic       jal;
    logic [3:0] aluc;
  } id_ex_ctrl_t;

endpackage

// File: rtl/pipe_alu.sv
// Combinational EX-stage ALU with logic ops, LUI and barrel shifts.
module pipe_alu
  import pipe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r
);

  logic [4:0] sa;
  assign sa = a[4:0];

  always_comb begin
    r = '0;
    casez (aluc)
      {1'b?, ALU_ADD[2:0]}: r = a + b;
      {1'b?, ALU_SUB[2:0]}: r = a - b;
      {1'b?, ALU_AND[2:0]}: r = a & b;
      {1'b?, ALU_OR[2:0]}:  r = a | b;
      {1'b?, ALU_XOR[2:0]}: r = a ^ b;
      {1'b?, ALU_LUI[2:0]}: r = {b[15:0], 16'h0000};
      ALU_SLL:              r = b << sa;
      ALU_SRL:              r = b >> sa;
      ALU_SRA:              r = 32'($signed(b) >>> sa);
      default:              r = '0;
    endcase
  end

endmodule

// File: rtl/pipe_exe_backend.sv
// ID/EX register with bubble insertion, EX datapath with jal link path,
// and the EX/MEM register feeding the data-memory stage.
module pipe_exe_backend
  import pipe_pkg::*;
#(
  parameter logic [4:0] LINK_REG = DEFAULT_LINK_REG,
  parameter int         CNT_W    = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wpcir,
  input  logic [31:0]      dpc4,
  input  logic [31:0]      da,
  input  logic [31:0]      db,
  input  logic [31:0]      dimm,
  input  logic [4:0]       drn,
  input  logic [3:0]       daluc,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic             daluimm,
  input  logic             dshift,
  input  logic             djal,
  output logic [31:0]      ealu,
  output logic [4:0]       ern,
  output logic             ewreg,
  output logic             em2reg,
  output logic [31:0]      malu,
  output logic [31:0]      mb,
  output logic [4:0]       mrn,
  output logic             mwreg,
  output logic             mm2reg,
  output logic             mwmem,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [31:0] epc4, ea, eb, eimm;
  logic [4:0]  ern_reg;
  id_ex_ctrl_t ectrl, dctrl;
  logic [31:0] alu_a, alu_b, alu_r;

  always_comb begin
    dctrl        = '0;
    dctrl.wreg   = dwreg;
    dctrl.m2reg  = dm2reg;
    dctrl.wmem   = dwmem;
    dctrl.aluimm = daluimm;
    dctrl.shift  = dshift;
    dctrl.jal    = djal;
    dctrl.aluc   = daluc;
    // A bubble keeps the data fields but must never write state or link.
    if (wpcir) begin
      dctrl.wreg  = 1'b0;
      dctrl.m2reg = 1'b0;
      dctrl.wmem  = 1'b0;
      dctrl.jal   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      epc4    <= '0;
      ea      <= '0;
      eb      <= '0;
      eimm    <= '0;
      ern_reg <= '0;
      ectrl   <= '0;
    end else begin
      epc4    <= dpc4;
      ea      <= da;
      eb      <= db;
      eimm    <= dimm;
      ern_reg <= drn;
      ectrl   <= dctrl;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bubble_cnt <= '0;
    end else if (wpcir && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign alu_a = ectrl.shift  ? eimm : ea;
  assign alu_b = ectrl.aluimm ? eimm : eb;

  pipe_alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .aluc (ectrl.aluc),
    .r    (alu_r)
  );

  // jal links past the delay slot, hence epc4 + 4.
  assign ealu   = ectrl.jal ? (epc4 + 32'd4) : alu_r;
  assign ern    = ectrl.jal ? LINK_REG : ern_reg;
  assign ewreg  = ectrl.wreg;
  assign em2reg = ectrl.m2reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      malu   <= '0;
      mb     <= '0;
      mrn    <= '0;
      mwreg  <= 1'b0;
      mm2reg <= 1'b0;
      mwmem  <= 1'b0;
    end else begin
      malu   <= ealu;
      mb     <= eb;
      mrn    <= ern;
      mwreg  <= ectrl.wreg;
      mm2reg <= ectrl.m2reg;
      mwmem  <= ectrl.wmem;
    end
  end

endmodule
